bit_serial_adder: RTL

- Sequential multi-bit adder built from the team's half-adder cell.
- Takes two WIDTH-bit operands LSB-first, one bit pair per accepted cycle, and closes the carry loop through a carry flip-flop.
- Emits each sum bit as it is produced and assembles the full result word.
- Sits directly downstream of the half-adder stage and is exposed on the Tiny Tapeout pins by the top-level wrapper.

---
 rtl/bit_serial_adder_pkg.sv | 18 +
 rtl/half_adder_cell.sv | 12 +
 rtl/bit_serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Bit-counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Half-adder cell: s = a ^ b, c = a & b.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder built from two half-adder cells and a carry flop.
// Optional signed-overflow flag enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             sum_bit,
    output logic             sum_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic             carry;
    logic [CNT_W-1:0] count;

    logic prop;
    logic gen;
    logic sum_c;
    logic gen2;
    logic carry_next_c;
    logic last_c;

    half_adder_cell u_ha_ab (
        .a (a_bit),
        .b (b_bit),
        .s (prop),
        .c (gen)
    );

    half_adder_cell u_ha_cin (
        .a (prop),
        .b (carry),
        .s (sum_c),
        .c (gen2)
    );

    assign carry_next_c = gen | gen2;
    assign last_c       = (count == CNT_W'(WIDTH - 1));

    // Control FSM with the sum/result datapath; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry     <= 1'b0;
            count     <= '0;
            sum_bit   <= 1'b0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            done      <= 1'b0;
            sum_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry     <= 1'b0;
                        count     <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        sum_bit   <= sum_c;
                        sum_valid <= 1'b1;
                        result    <= {sum_c, result[WIDTH-1:1]};
                        carry     <= carry_next_c;
                        count     <= count + CNT_W'(1);
                        if (last_c) begin
                            carry_out <= carry_next_c;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BIT_SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (state == RUN && in_valid && last_c) begin
            ovf <= carry ^ carry_next_c;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
